fetch_stage: RTL and testbench

Y86-64 fetch stage for the pipelined processor. Holds the PC and the PC-select state machine, and splits the 10-byte instruction window into fields. Computes valP and the predicted next PC, and drives the F/D pipeline register consumed by decode. The combinational predecoder (need_regids / need_valC from icode) is external; this block drives its icode input and consumes its outputs.

---
 rtl/y86_pkg.sv | 48 ++++
 rtl/fetch_align.sv | 61 ++++++
 rtl/fetch_stage.sv | 141 ++++++++++++++
 tb/tb_fetch_stage.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : y86_pkg
//  Description : Shared Y86-64 encodings: instruction codes, status codes,
//                register-none marker, pipeline bubble values and fetch FSM
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package y86_pkg;

   // Instruction codes (byte0[7:4])
   localparam logic [3:0] c_ICODE_HALT   = 4'h0;
   localparam logic [3:0] c_ICODE_NOP    = 4'h1;
   localparam logic [3:0] c_ICODE_RRMOVQ = 4'h2;
   localparam logic [3:0] c_ICODE_IRMOVQ = 4'h3;
   localparam logic [3:0] c_ICODE_RMMOVQ = 4'h4;
   localparam logic [3:0] c_ICODE_MRMOVQ = 4'h5;
   localparam logic [3:0] c_ICODE_OPQ    = 4'h6;
   localparam logic [3:0] c_ICODE_JXX    = 4'h7;
   localparam logic [3:0] c_ICODE_CALL   = 4'h8;
   localparam logic [3:0] c_ICODE_RET    = 4'h9;
   localparam logic [3:0] c_ICODE_PUSHQ  = 4'hA;
   localparam logic [3:0] c_ICODE_POPQ   = 4'hB;

   // Instruction status carried down the pipe
   typedef enum logic [2:0] {
      STAT_AOK = 3'd1,
      STAT_HLT = 3'd2,
      STAT_ADR = 3'd3,
      STAT_INS = 3'd4
   } stat_e;

   // Register field value meaning "no register"
   localparam logic [3:0] c_RNONE = 4'hF;

   // Nop bubble injected into F/D
   localparam stat_e      c_BUBBLE_STAT  = STAT_AOK;
   localparam logic [3:0] c_BUBBLE_ICODE = c_ICODE_NOP;
   localparam logic [3:0] c_BUBBLE_IFUN  = 4'h0;

   // Fetch PC-select state machine
   typedef enum logic [0:0] {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_align.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_align
//  Description : Combinational split of the 10-byte instruction window into
//                Y86-64 fields, fall-through PC, predicted PC and fetch status.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_align
   import y86_pkg::*;
#(
   parameter int ADDR_W = 64
) (
   input  logic [ADDR_W-1:0] i_pc,
   input  logic [79:0]       i_bytes,
   input  logic              i_imem_error,
   input  logic              i_need_regids,
   input  logic              i_need_valc,
   output logic [3:0]        o_icode,
   output logic [3:0]        o_ifun,
   output logic [3:0]        o_ra,
   output logic [3:0]        o_rb,
   output logic [ADDR_W-1:0] o_valc,
   output logic [ADDR_W-1:0] o_valp,
   output logic [ADDR_W-1:0] o_pred_pc,
   output stat_e             o_stat
);

   logic [63:0]       w_const_raw;
   logic [3:0]        w_pc_inc;

   // Field extraction; the constant shifts up one byte when a register byte is present
   always_comb begin
      o_icode     = i_bytes[7:4];
      o_ifun      = i_bytes[3:0];
      o_ra        = i_need_regids ? i_bytes[15:12] : c_RNONE;
      o_rb        = i_need_regids ? i_bytes[11:8]  : c_RNONE;
      w_const_raw = i_need_regids ? i_bytes[79:16] : i_bytes[71:8];
      o_valc      = i_need_valc ? w_const_raw[ADDR_W-1:0] : {ADDR_W{1'b0}};
   end

   // Fall-through PC (wraps silently) and branch/call target prediction
   always_comb begin
      w_pc_inc  = 4'd1 + {3'd0, i_need_regids} + (i_need_valc ? 4'd8 : 4'd0);
      o_valp    = i_pc + {{(ADDR_W-4){1'b0}}, w_pc_inc};
      o_pred_pc = ((o_icode == c_ICODE_JXX) || (o_icode == c_ICODE_CALL)) ? o_valc : o_valp;
   end

   // Fetch status, memory fault takes precedence over decode faults
   always_comb begin
      if (i_imem_error)
         o_stat = STAT_ADR;
      else if (o_icode > c_ICODE_POPQ)
         o_stat = STAT_INS;
      else if (o_icode == c_ICODE_HALT)
         o_stat = STAT_HLT;
      else
         o_stat = STAT_AOK;
   end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Y86-64 fetch stage: PC register, RUN/HALTED PC-select state
//                machine and the F/D pipeline register feeding decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
   import y86_pkg::*;
#(
   parameter int                ADDR_W   = 64,
   parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [79:0]       imem_bytes,
   input  logic              imem_error,
   output logic [ADDR_W-1:0] f_pc,
   output logic [3:0]        f_icode,
   input  logic              need_regids,
   input  logic              need_valC,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              stall_f,
   input  logic              stall_d,
   input  logic              bubble_d,
   output logic [2:0]        d_stat,
   output logic [3:0]        d_icode,
   output logic [3:0]        d_ifun,
   output logic [3:0]        d_rA,
   output logic [3:0]        d_rB,
   output logic [ADDR_W-1:0] d_valC,
   output logic [ADDR_W-1:0] d_valP,
   output logic              halted
);

   fetch_state_e      r_state;
   fetch_state_e      w_state_nxt;
   logic [ADDR_W-1:0] r_pc;

   logic [3:0]        w_icode;
   logic [3:0]        w_ifun;
   logic [3:0]        w_ra;
   logic [3:0]        w_rb;
   logic [ADDR_W-1:0] w_valc;
   logic [ADDR_W-1:0] w_valp;
   logic [ADDR_W-1:0] w_pred_pc;
   stat_e             w_stat;
   logic              w_fd_load;

   stat_e             r_fd_stat;
   logic [3:0]        r_fd_icode;
   logic [3:0]        r_fd_ifun;
   logic [3:0]        r_fd_ra;
   logic [3:0]        r_fd_rb;
   logic [ADDR_W-1:0] r_fd_valc;
   logic [ADDR_W-1:0] r_fd_valp;

   fetch_align #(
      .ADDR_W (ADDR_W)
   ) u_align (
      .i_pc          (r_pc),
      .i_bytes       (imem_bytes),
      .i_imem_error  (imem_error),
      .i_need_regids (need_regids),
      .i_need_valc   (need_valC),
      .o_icode       (w_icode),
      .o_ifun        (w_ifun),
      .o_ra          (w_ra),
      .o_rb          (w_rb),
      .o_valc        (w_valc),
      .o_valp        (w_valp),
      .o_pred_pc     (w_pred_pc),
      .o_stat        (w_stat)
   );

   // A real fetched instruction enters F/D only when running and not stalled/bubbled
   assign w_fd_load = !bubble_d && !stall_d && (r_state == ST_RUN);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= ST_RUN;
      else
         r_state <= w_state_nxt;
   end

   // Next state: stop on a faulting instruction, resume only on a redirect
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN:    if (w_fd_load && (w_stat != STAT_AOK)) w_state_nxt = ST_HALTED;
         ST_HALTED: if (redirect_valid)                    w_state_nxt = ST_RUN;
         default:   w_state_nxt = ST_RUN;
      endcase
   end

   // PC register: redirect beats stall and halt; otherwise follow the prediction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_pc <= RESET_PC;
      else if (redirect_valid)
         r_pc <= redirect_pc;
      else if (!stall_f && (r_state == ST_RUN))
         r_pc <= w_pred_pc;
   end

   // F/D register: bubble, hold, halted bubble, or load the fetched fields
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || bubble_d || (!stall_d && (r_state == ST_HALTED))) begin
         r_fd_stat  <= c_BUBBLE_STAT;
         r_fd_icode <= c_BUBBLE_ICODE;
         r_fd_ifun  <= c_BUBBLE_IFUN;
         r_fd_ra    <= c_RNONE;
         r_fd_rb    <= c_RNONE;
         r_fd_valc  <= {ADDR_W{1'b0}};
         r_fd_valp  <= {ADDR_W{1'b0}};
      end else if (w_fd_load) begin
         r_fd_stat  <= w_stat;
         r_fd_icode <= w_icode;
         r_fd_ifun  <= w_ifun;
         r_fd_ra    <= w_ra;
         r_fd_rb    <= w_rb;
         r_fd_valc  <= w_valc;
         r_fd_valp  <= w_valp;
      end
   end

   assign f_pc    = r_pc;
   assign f_icode = imem_bytes[7:4];
   assign halted  = (r_state == ST_HALTED);
   assign d_stat  = r_fd_stat;
   assign d_icode = r_fd_icode;
   assign d_ifun  = r_fd_ifun;
   assign d_rA    = r_fd_ra;
   assign d_rB    = r_fd_rb;
   assign d_valC  = r_fd_valc;
   assign d_valP  = r_fd_valp;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Self-checking bench for fetch_stage with a predecoder model
//                and an F/D scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

   localparam logic [63:0] c_RST_PC = 64'h100;
   localparam logic [79:0] c_NOP    = 80'h10;
   localparam logic [79:0] c_HALT   = 80'h00;
   localparam logic [79:0] c_BADOP  = 80'hC0;
   localparam logic [79:0] c_IRMOV  = 80'h1122334455667788F330;
   localparam logic [79:0] c_JMP400 = 80'h00000000000000040070;

   logic        clk;
   logic        rst_n;
   logic [79:0] imem_bytes;
   logic        imem_error;
   logic [63:0] f_pc;
   logic [3:0]  f_icode;
   logic        need_regids;
   logic        need_valC;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        stall_f;
   logic        stall_d;
   logic        bubble_d;
   logic [2:0]  d_stat;
   logic [3:0]  d_icode;
   logic [3:0]  d_ifun;
   logic [3:0]  d_rA;
   logic [3:0]  d_rB;
   logic [63:0] d_valC;
   logic [63:0] d_valP;
   logic        halted;

   typedef struct {
      logic [2:0]  stat;
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [63:0] valc;
      logic [63:0] valp;
   } fd_t;

   fd_t         sb[$];
   fd_t         m_fd;
   logic [63:0] m_pc;
   bit          m_halted;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_cyc    = 0;

   fetch_stage #(
      .ADDR_W   (64),
      .RESET_PC (c_RST_PC)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_bytes     (imem_bytes),
      .imem_error     (imem_error),
      .f_pc           (f_pc),
      .f_icode        (f_icode),
      .need_regids    (need_regids),
      .need_valC      (need_valC),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .stall_f        (stall_f),
      .stall_d        (stall_d),
      .bubble_d       (bubble_d),
      .d_stat         (d_stat),
      .d_icode        (d_icode),
      .d_ifun         (d_ifun),
      .d_rA           (d_rA),
      .d_rB           (d_rB),
      .d_valC         (d_valC),
      .d_valP         (d_valP),
      .halted         (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic pd_regids(input logic [3:0] ic);
      return (ic == 4'h2) || (ic == 4'h3) || (ic == 4'h4) || (ic == 4'h5) ||
             (ic == 4'h6) || (ic == 4'hA) || (ic == 4'hB);
   endfunction

   function automatic logic pd_valc(input logic [3:0] ic);
      return (ic == 4'h3) || (ic == 4'h4) || (ic == 4'h5) || (ic == 4'h7) || (ic == 4'h8);
   endfunction

   // External predecoder model
   always_comb begin
      need_regids = pd_regids(f_icode);
      need_valC   = pd_valc(f_icode);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic fd_t bubble_val();
      fd_t b;
      b.stat = 3'd1; b.icode = 4'h1; b.ifun = 4'h0;
      b.ra = 4'hF; b.rb = 4'hF; b.valc = 64'd0; b.valp = 64'd0;
      return b;
   endfunction

   task automatic ref_fetch(input logic [79:0] b, input logic [63:0] pc, input logic err,
                            output fd_t f, output logic [63:0] pred);
      logic nr, nv;
      f.icode = b[7:4];
      f.ifun  = b[3:0];
      nr      = pd_regids(f.icode);
      nv      = pd_valc(f.icode);
      f.ra    = nr ? b[15:12] : 4'hF;
      f.rb    = nr ? b[11:8]  : 4'hF;
      f.valc  = nv ? (nr ? b[79:16] : b[71:8]) : 64'd0;
      f.valp  = pc + 64'd1 + {63'd0, nr} + (nv ? 64'd8 : 64'd0);
      f.stat  = err ? 3'd3 : (f.icode > 4'hB) ? 3'd4 : (f.icode == 4'h0) ? 3'd2 : 3'd1;
      pred    = ((f.icode == 4'h7) || (f.icode == 4'h8)) ? f.valc : f.valp;
   endtask

   // Drive one cycle of stimulus, push the expected F/D, then compare after the edge
   task automatic cycle(input logic [79:0] b, input logic err, input logic redir,
                        input logic [63:0] rpc, input logic sf, input logic sd, input logic bd);
      fd_t         f, nfd, e;
      logic [63:0] pred, npc;
      bit          nh;
      imem_bytes     = b;
      imem_error     = err;
      redirect_valid = redir;
      redirect_pc    = rpc;
      stall_f        = sf;
      stall_d        = sd;
      bubble_d       = bd;
      ref_fetch(b, m_pc, err, f, pred);
      nfd = bd ? bubble_val() : sd ? m_fd : m_halted ? bubble_val() : f;
      nh  = m_halted ? !redir : (!bd && !sd && (f.stat != 3'd1));
      npc = redir ? rpc : (sf || m_halted) ? m_pc : pred;
      sb.push_back(nfd);
      @(posedge clk);
      #1;
      n_cyc++;
      e = sb.pop_front();
      check($sformatf("c%0d.d_stat", n_cyc), {61'd0, d_stat}, {61'd0, e.stat});
      check($sformatf("c%0d.d_icode", n_cyc), {60'd0, d_icode}, {60'd0, e.icode});
      check($sformatf("c%0d.d_ifun", n_cyc), {60'd0, d_ifun}, {60'd0, e.ifun});
      check($sformatf("c%0d.d_rA", n_cyc), {60'd0, d_rA}, {60'd0, e.ra});
      check($sformatf("c%0d.d_rB", n_cyc), {60'd0, d_rB}, {60'd0, e.rb});
      check($sformatf("c%0d.d_valC", n_cyc), d_valC, e.valc);
      check($sformatf("c%0d.d_valP", n_cyc), d_valP, e.valp);
      check($sformatf("c%0d.f_pc", n_cyc), f_pc, npc);
      check($sformatf("c%0d.halted", n_cyc), {63'd0, halted}, {63'd0, nh});
      m_pc     = npc;
      m_halted = nh;
      m_fd     = nfd;
   endtask

   initial begin
      rst_n = 1'b1; imem_bytes = c_NOP; imem_error = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 64'd0;
      stall_f = 1'b0; stall_d = 1'b0; bubble_d = 1'b0;
      #2 rst_n = 1'b0;
      #10;
      check("rst.f_pc", f_pc, 64'h100);
      check("rst.d_icode", {60'd0, d_icode}, 64'd1);
      check("rst.d_stat", {61'd0, d_stat}, 64'd1);
      check("rst.halted", {63'd0, halted}, 64'd0);
      rst_n    = 1'b1;
      m_pc     = c_RST_PC;
      m_halted = 1'b0;
      m_fd     = bubble_val();

      // irmovq $0x1122334455667788,%rbx
      cycle(c_IRMOV, 0, 0, 0, 0, 0, 0);
      check("irmov.d_rB", {60'd0, d_rB}, 64'h3);
      check("irmov.d_rA", {60'd0, d_rA}, 64'hF);
      check("irmov.d_valC", d_valC, 64'h1122334455667788);
      check("irmov.d_valP", d_valP, 64'h10A);
      check("irmov.f_pc", f_pc, 64'h10A);

      // jmp 0x400 at 0x20, then again with a simultaneous redirect
      cycle(c_NOP, 0, 1, 64'h20, 0, 0, 0);
      cycle(c_JMP400, 0, 0, 0, 0, 0, 0);
      check("jmp.d_valP", d_valP, 64'h29);
      check("jmp.f_pc", f_pc, 64'h400);
      cycle(c_NOP, 0, 1, 64'h20, 0, 0, 0);
      cycle(c_JMP400, 0, 1, 64'h500, 0, 0, 0);
      check("jmp_redir.f_pc", f_pc, 64'h500);

      // halt freezes fetch until a redirect
      cycle(c_HALT, 0, 0, 0, 0, 0, 0);
      check("halt.d_stat", {61'd0, d_stat}, 64'd2);
      check("halt.halted", {63'd0, halted}, 64'd1);
      cycle(c_NOP, 0, 0, 0, 0, 0, 0);
      cycle(c_IRMOV, 0, 0, 0, 0, 0, 0);
      check("halted.f_pc", f_pc, 64'h501);
      check("halted.d_icode", {60'd0, d_icode}, 64'd1);
      cycle(c_NOP, 0, 1, 64'h80, 0, 0, 0);
      check("resume.halted", {63'd0, halted}, 64'd0);
      check("resume.f_pc", f_pc, 64'h80);

      // illegal icode, then memory error taking priority
      cycle(c_BADOP, 0, 0, 0, 0, 0, 0);
      check("ins.d_stat", {61'd0, d_stat}, 64'd4);
      cycle(c_NOP, 0, 1, 64'h90, 0, 0, 0);
      cycle(c_BADOP, 1, 0, 0, 0, 0, 0);
      check("adr.d_stat", {61'd0, d_stat}, 64'd3);
      check("adr.halted", {63'd0, halted}, 64'd1);
      cycle(c_NOP, 0, 1, 64'h100, 0, 0, 0);

      // stalls hold both PC and F/D; bubble beats stall
      cycle(c_IRMOV, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle(c_JMP400, 0, 0, 0, 1, 1, 0);
      check("stall.f_pc", f_pc, 64'h10A);
      check("stall.d_valC", d_valC, 64'h1122334455667788);
      cycle(c_NOP, 0, 0, 0, 0, 1, 1);
      check("bubble.d_icode", {60'd0, d_icode}, 64'd1);
      check("bubble.d_valC", d_valC, 64'd0);

      // asynchronous reset in the middle of a cycle
      cycle(c_HALT, 0, 0, 0, 0, 0, 0);
      #3 rst_n = 1'b0;
      #1;
      check("arst.f_pc", f_pc, 64'h100);
      check("arst.d_icode", {60'd0, d_icode}, 64'd1);
      check("arst.d_stat", {61'd0, d_stat}, 64'd1);
      check("arst.d_valP", d_valP, 64'd0);
      check("arst.halted", {63'd0, halted}, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
